// File: rtl/counter_4b_pkg.sv
// -----------------------------------------------------------------------------
// counter_4b_pkg
//   Shared definitions for the 4-bit mode counter checker:
//     - mode_e   : counter mode encoding carried on MODO
//     - state_e  : checker synchronisation state
//     - CNT_W_DEF: default width of the saturating error/check counters
//     - is_sync_stim(): true when the sampled stimulus fully determines the
//       counter's next state, independent of its current Q
// -----------------------------------------------------------------------------
package counter_4b_pkg;

    localparam int CNT_W_DEF = 8;

    typedef enum logic [1:0] {
        MODE_UP  = 2'b00,   // Q + 1
        MODE_DN  = 2'b01,   // Q - 1
        MODE_UP3 = 2'b10,   // Q + 3
        MODE_LD  = 2'b11    // Q = D
    } mode_e;

    typedef enum logic {
        ST_UNSYNC = 1'b0,   // reference state unknown, no compares
        ST_CHECK  = 1'b1    // reference state valid, compare every edge
    } state_e;

    // A counter reset, a disabled counter or a load all produce a next state
    // that does not depend on the previous Q, so the reference can lock on.
    function automatic logic is_sync_stim(input logic       dut_reset,
                                          input logic       enable,
                                          input logic [1:0] modo);
        return dut_reset || !enable || (mode_e'(modo) == MODE_LD);
    endfunction

endpackage : counter_4b_pkg

// File: rtl/counter_4b_ref_model.sv
// -----------------------------------------------------------------------------
// counter_4b_ref_model
//   Purely combinational next-state function of the 4-bit mode counter.
//   Given the current (expected) count and the stimulus sampled on an edge,
//   produces the count, ripple-carry and load indicator the counter should
//   present after that edge.
//
//   Configuration macro: CHK_RCO_EN
//     defined   -> rco_nxt port and its logic exist
//     undefined -> no ripple-carry prediction is built
//
//   Ports
//     q_in       in   4  current expected count
//     DUT_RESET  in   1  counter reset sampled on this edge
//     ENABLE     in   1  counter enable sampled on this edge
//     MODO       in   2  counter mode sampled on this edge
//     D          in   4  counter load data sampled on this edge
//     q_nxt      out  4  predicted count after the edge
//     rco_nxt    out  1  predicted ripple-carry after the edge (CHK_RCO_EN)
//     load_nxt   out  1  predicted load indicator after the edge
// -----------------------------------------------------------------------------
module counter_4b_ref_model
    import counter_4b_pkg::*;
(
    input  logic [3:0] q_in,
    input  logic       DUT_RESET,
    input  logic       ENABLE,
    input  logic [1:0] MODO,
    input  logic [3:0] D,
    output logic [3:0] q_nxt,
`ifdef CHK_RCO_EN
    output logic       rco_nxt,
`endif
    output logic       load_nxt
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would otherwise infer a latch.
        q_nxt    = 4'h0;
        load_nxt = 1'b0;
`ifdef CHK_RCO_EN
        rco_nxt  = 1'b0;
`endif
        // Reset and disable both force the all-zero output set, which is
        // exactly the defaults above.
        if (!DUT_RESET && ENABLE) begin
            unique case (mode_e'(MODO))
                MODE_LD: begin
                    q_nxt    = D;
                    load_nxt = 1'b1;
                end
                MODE_UP: begin
                    q_nxt = q_in + 4'd1;
`ifdef CHK_RCO_EN
                    rco_nxt = (q_in == 4'hF);
`endif
                end
                MODE_UP3: begin
                    q_nxt = q_in + 4'd3;
`ifdef CHK_RCO_EN
                    // Carry out of the 5-bit sum Q + 3.
                    rco_nxt = (q_in >= 4'd13);
`endif
                end
                MODE_DN: begin
                    q_nxt = q_in - 4'd1;
`ifdef CHK_RCO_EN
                    // Borrow out when decrementing from zero.
                    rco_nxt = (q_in == 4'h0);
`endif
                end
                default: begin
                    q_nxt = 4'h0;
                end
            endcase
        end
    end

endmodule : counter_4b_ref_model

// File: rtl/counter_4b_checker.sv
// -----------------------------------------------------------------------------
// counter_4b_checker
//   Receive-side checker for the 4-bit mode counter. Samples the stimulus fed
//   to the counter together with the outputs the counter returns, tracks a
//   reference copy of the counter state, and flags every compare in which the
//   counter's outputs disagree with the reference.
//
//   Timing: stimulus sampled on edge k produces the expected registers after
//   edge k; the counter's outputs are compared against them on edge k+1, and
//   ERR is visible in the cycle following edge k+1.
//
//   Configuration macro: CHK_RCO_EN
//     defined   -> RCO takes part in the compare
//     undefined -> RCO is ignored and no expected-RCO logic is built
//                  (needed for the gate-level counter whose RCO is tied low)
//
//   Parameters
//     CNT_W        width of the saturating ERR_CNT / CHK_CNT counters
//
//   Ports
//     clk          in   1      rising-edge clock
//     RESET        in   1      checker reset, synchronous, active-high
//     DUT_RESET    in   1      copy of the counter's reset
//     ENABLE       in   1      copy of the counter's enable
//     MODO         in   2      copy of the counter's mode
//     D            in   4      copy of the counter's load data
//     Q            in   4      counter count output
//     RCO          in   1      counter ripple-carry output
//     LOAD         in   1      counter load-indicator output
//     SYNCED       out  1      reference valid, compares active
//     ERR          out  1      one-cycle mismatch pulse
//     ERR_STICKY   out  1      latched mismatch flag, cleared by RESET only
//     ERR_CNT      out  CNT_W  saturating mismatch count
//     CHK_CNT      out  CNT_W  saturating compare count
//     EXP_Q        out  4      expected Q for the compare on the next edge
// -----------------------------------------------------------------------------
module counter_4b_checker
    import counter_4b_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             RESET,
    input  logic             DUT_RESET,
    input  logic             ENABLE,
    input  logic [1:0]       MODO,
    input  logic [3:0]       D,
    input  logic [3:0]       Q,
    input  logic             RCO,
    input  logic             LOAD,
    output logic             SYNCED,
    output logic             ERR,
    output logic             ERR_STICKY,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic [CNT_W-1:0] CHK_CNT,
    output logic [3:0]       EXP_Q
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // State and reference registers
    // ------------------------------------------------------------------
    state_e           state;
    state_e           state_nxt;

    logic [3:0]       exp_q;
    logic             exp_load;
    logic [3:0]       model_q;
    logic             model_load;

`ifdef CHK_RCO_EN
    logic             exp_rco;
    logic             model_rco;
`else
    // RCO carries no information in this build; keep it visibly consumed.
    logic             unused_rco;
    assign unused_rco = RCO;
`endif

    logic             err_q;
    logic             err_sticky_q;
    logic [CNT_W-1:0] err_cnt_q;
    logic [CNT_W-1:0] chk_cnt_q;

    logic             do_cmp;
    logic             mismatch;

    // ------------------------------------------------------------------
    // Reference model: next counter outputs from the *expected* count, so a
    // single bad Q from the counter does not corrupt later predictions.
    // ------------------------------------------------------------------
    counter_4b_ref_model u_ref_model (
        .q_in      (exp_q),
        .DUT_RESET (DUT_RESET),
        .ENABLE    (ENABLE),
        .MODO      (MODO),
        .D         (D),
        .q_nxt     (model_q),
`ifdef CHK_RCO_EN
        .rco_nxt   (model_rco),
`endif
        .load_nxt  (model_load)
    );

    // ------------------------------------------------------------------
    // Next-state logic: lock on once the stimulus determines the counter
    // state on its own; after that stay locked until RESET.
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_UNSYNC: begin
                if (is_sync_stim(DUT_RESET, ENABLE, MODO)) begin
                    state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                state_nxt = ST_CHECK;
            end
            default: begin
                state_nxt = ST_UNSYNC;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Compare: the expected registers hold the prediction made on the
    // previous edge, which is valid only if the checker was already locked.
    // ------------------------------------------------------------------
    always_comb begin
        do_cmp   = (state == ST_CHECK);
        mismatch = (Q != exp_q) || (LOAD != exp_load);
`ifdef CHK_RCO_EN
        mismatch = mismatch || (RCO != exp_rco);
`endif
    end

    // ------------------------------------------------------------------
    // Sequential state. RESET has priority over everything, including a
    // mismatch observed on the same edge.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments throughout, so every register here
        // samples the pre-edge values of the others regardless of order.
        if (RESET) begin
            state        <= ST_UNSYNC;
            exp_q        <= 4'h0;
            exp_load     <= 1'b0;
`ifdef CHK_RCO_EN
            exp_rco      <= 1'b0;
`endif
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            err_cnt_q    <= '0;
            chk_cnt_q    <= '0;
        end else begin
            state    <= state_nxt;
            exp_q    <= model_q;
            exp_load <= model_load;
`ifdef CHK_RCO_EN
            exp_rco  <= model_rco;
`endif
            err_q    <= do_cmp && mismatch;

            if (do_cmp) begin
                if (chk_cnt_q != CNT_MAX) begin
                    chk_cnt_q <= chk_cnt_q + CNT_ONE;
                end
                if (mismatch) begin
                    err_sticky_q <= 1'b1;
                    if (err_cnt_q != CNT_MAX) begin
                        err_cnt_q <= err_cnt_q + CNT_ONE;
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign SYNCED     = (state == ST_CHECK);
    assign ERR        = err_q;
    assign ERR_STICKY = err_sticky_q;
    assign ERR_CNT    = err_cnt_q;
    assign CHK_CNT    = chk_cnt_q;
    assign EXP_Q      = exp_q;

endmodule : counter_4b_checker

// File: tb/tb_counter_4b_checker.sv
// -----------------------------------------------------------------------------
// tb_counter_4b_checker
//   Directed bench for counter_4b_checker. The bench plays the role of both
//   the stimulus generator and the counter: each step drives the stimulus for
//   the coming edge together with the counter outputs produced by the
//   previous edge's stimulus (hand-computed), then checks the checker's
//   registered outputs 1 ns after the edge.
//   dut8 uses the default counter width; dut2 uses CNT_W=2 for saturation.
// -----------------------------------------------------------------------------
module tb_counter_4b_checker;

    logic       clk;
    logic       RESET;
    logic       DUT_RESET;
    logic       ENABLE;
    logic [1:0] MODO;
    logic [3:0] D;
    logic [3:0] Q;
    logic       RCO;
    logic       LOAD;

    logic       synced8, err8, sticky8;
    logic [7:0] errcnt8, chkcnt8;
    logic [3:0] expq8;

    logic       synced2, err2, sticky2;
    logic [1:0] errcnt2, chkcnt2;
    logic [3:0] expq2;

    int errors = 0;
    int checks = 0;
    int exp_err_cnt;

    counter_4b_checker #(.CNT_W(8)) dut8 (
        .clk        (clk),
        .RESET      (RESET),
        .DUT_RESET  (DUT_RESET),
        .ENABLE     (ENABLE),
        .MODO       (MODO),
        .D          (D),
        .Q          (Q),
        .RCO        (RCO),
        .LOAD       (LOAD),
        .SYNCED     (synced8),
        .ERR        (err8),
        .ERR_STICKY (sticky8),
        .ERR_CNT    (errcnt8),
        .CHK_CNT    (chkcnt8),
        .EXP_Q      (expq8)
    );

    counter_4b_checker #(.CNT_W(2)) dut2 (
        .clk        (clk),
        .RESET      (RESET),
        .DUT_RESET  (DUT_RESET),
        .ENABLE     (ENABLE),
        .MODO       (MODO),
        .D          (D),
        .Q          (Q),
        .RCO        (RCO),
        .LOAD       (LOAD),
        .SYNCED     (synced2),
        .ERR        (err2),
        .ERR_STICKY (sticky2),
        .ERR_CNT    (errcnt2),
        .CHK_CNT    (chkcnt2),
        .EXP_Q      (expq2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus plus counter outputs, then advance past the edge.
    task automatic step(input logic rst, input logic dres, input logic en,
                        input logic [1:0] modo, input logic [3:0] d,
                        input logic [3:0] q, input logic rco, input logic load);
        RESET     = rst;
        DUT_RESET = dres;
        ENABLE    = en;
        MODO      = modo;
        D         = d;
        Q         = q;
        RCO       = rco;
        LOAD      = load;
        @(posedge clk);
        #1;
    endtask

    initial begin
        RESET = 1'b1; DUT_RESET = 1'b0; ENABLE = 1'b1; MODO = 2'b00;
        D = 4'h0; Q = 4'h0; RCO = 1'b0; LOAD = 1'b0;

        // ---- 1. checker reset, then counter reset to lock on ----
        step(1, 0, 1, 2'b00, 4'h0, 4'h0, 0, 0);
        step(1, 0, 1, 2'b00, 4'h0, 4'h0, 0, 0);
        check("rst_synced",  8'(synced8), 8'h0);
        check("rst_err",     8'(err8),    8'h0);
        check("rst_sticky",  8'(sticky8), 8'h0);
        check("rst_errcnt",  errcnt8,     8'h0);
        check("rst_chkcnt",  chkcnt8,     8'h0);
        check("rst_expq",    8'(expq8),   8'h0);

        step(0, 1, 1, 2'b00, 4'h0, 4'h7, 0, 0);      // DUT_RESET sampled -> lock
        check("t1_synced",   8'(synced8), 8'h1);
        check("t1_chk0",     chkcnt8,     8'h0);
        check("t1_expq0",    8'(expq8),   8'h0);

        // ---- 2. load D then count up across the wrap ----
        step(0, 0, 1, 2'b11, 4'hD, 4'h0, 0, 0);      // Q=0 from reset
        check("t1_err",      8'(err8),    8'h0);
        check("t1_chk1",     chkcnt8,     8'h1);
        check("t2_expD",     8'(expq8),   8'hD);
        step(0, 0, 1, 2'b00, 4'h0, 4'hD, 0, 1);      // Q=D, LOAD=1
        check("t2_expE",     8'(expq8),   8'hE);
        step(0, 0, 1, 2'b00, 4'h0, 4'hE, 0, 0);
        check("t2_expF",     8'(expq8),   8'hF);
        step(0, 0, 1, 2'b00, 4'h0, 4'hF, 0, 0);
        check("t2_exp0",     8'(expq8),   8'h0);
        check("t2_err",      8'(err8),    8'h0);
        // Wrap result Q=0 RCO=1 LOAD=0; stimulus loads 1 for the next test.
        step(0, 0, 1, 2'b11, 4'h1, 4'h0, 1, 0);
        check("t2_wrap_err", 8'(err8),    8'h0);
        check("t2_chk5",     chkcnt8,     8'h5);
        check("t3_exp1",     8'(expq8),   8'h1);

        // ---- 3. count down through zero, then a wrong Q ----
        step(0, 0, 1, 2'b01, 4'h0, 4'h1, 0, 1);      // Q=1 loaded
        check("t3_exp0",     8'(expq8),   8'h0);
        step(0, 0, 1, 2'b01, 4'h0, 4'h0, 0, 0);
        check("t3_expF",     8'(expq8),   8'hF);
        check("t3_noerr",    8'(err8),    8'h0);
        step(0, 0, 1, 2'b11, 4'hC, 4'hE, 1, 0);      // counter wrongly shows E
        check("t3_err",      8'(err8),    8'h1);
        check("t3_errcnt",   errcnt8,     8'h1);
        check("t3_sticky",   8'(sticky8), 8'h1);
        check("t3_chk8",     chkcnt8,     8'h8);

        // ---- 4. +3 from C, then disable mid-run ----
        step(0, 0, 1, 2'b10, 4'h0, 4'hC, 0, 1);      // Q=C loaded
        check("t3_pulse",    8'(err8),    8'h0);
        check("t3_sticky2",  8'(sticky8), 8'h1);
        check("t4_expF",     8'(expq8),   8'hF);
        step(0, 0, 1, 2'b10, 4'h0, 4'hF, 0, 0);
        check("t4_exp2",     8'(expq8),   8'h2);
        step(0, 0, 0, 2'b10, 4'h0, 4'h2, 1, 0);      // ENABLE=0 sampled
        check("t4_exp_dis",  8'(expq8),   8'h0);
        check("t4_err",      8'(err8),    8'h0);
        step(0, 0, 1, 2'b00, 4'h0, 4'h0, 0, 0);
        check("t4_err2",     8'(err8),    8'h0);
        check("t4_errcnt",   errcnt8,     8'h1);
        check("t4_exp1",     8'(expq8),   8'h1);

        // Counter reset mid-run: checker stays locked, expected Q returns to 0.
        step(0, 1, 1, 2'b00, 4'h0, 4'h1, 0, 0);
        check("dr_synced",   8'(synced8), 8'h1);
        check("dr_exp0",     8'(expq8),   8'h0);
        step(0, 0, 1, 2'b00, 4'h0, 4'h0, 0, 0);
        check("dr_err",      8'(err8),    8'h0);
        check("dr_chk",      chkcnt8,     8'd14);
        check("dr_exp1",     8'(expq8),   8'h1);

        // Wrong RCO with correct Q: an error only when RCO is compared.
        step(0, 0, 1, 2'b00, 4'h0, 4'h1, 1, 0);
`ifdef CHK_RCO_EN
        exp_err_cnt = 2;
        check("rco_err",     8'(err8),    8'h1);
`else
        exp_err_cnt = 1;
        check("rco_err",     8'(err8),    8'h0);
`endif
        check("rco_errcnt",  errcnt8,     8'(exp_err_cnt));
        check("rco_chk",     chkcnt8,     8'd15);

        // ---- RESET coincident with a mismatch (Q=9, expected 2) ----
        step(1, 0, 1, 2'b00, 4'h0, 4'h9, 0, 0);
        check("rm_err",      8'(err8),    8'h0);
        check("rm_errcnt",   errcnt8,     8'h0);
        check("rm_chkcnt",   chkcnt8,     8'h0);
        check("rm_sticky",   8'(sticky8), 8'h0);
        check("rm_synced",   8'(synced8), 8'h0);

        // ---- 5. counting before sync: no compares ----
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 1, 2'b00, 4'h0, 4'($urandom_range(15)), 1'($urandom_range(1)), 0);
            check("us_synced", 8'(synced8), 8'h0);
            check("us_chkcnt", chkcnt8,     8'h0);
            check("us_err",    8'(err8),    8'h0);
        end

        // ---- 6. CNT_W=2 saturation, then RESET over a mismatch ----
        step(0, 1, 1, 2'b00, 4'h0, 4'h3, 0, 0);      // lock on
        check("s_synced",    8'(synced2), 8'h1);
        for (int n = 1; n <= 5; n++) begin
            step(0, 1, 1, 2'b00, 4'h0, 4'h5, 0, 0);  // expected 0, observed 5
            check("s_err",    8'(err2),    8'h1);
            check("s_sticky", 8'(sticky2), 8'h1);
            check("s_errcnt", 8'(errcnt2), 8'((n < 3) ? n : 3));
            check("s_chkcnt", 8'(chkcnt2), 8'((n < 3) ? n : 3));
        end
        step(1, 1, 1, 2'b00, 4'h0, 4'h5, 0, 0);
        check("sr_err",      8'(err2),    8'h0);
        check("sr_sticky",   8'(sticky2), 8'h0);
        check("sr_errcnt",   8'(errcnt2), 8'h0);
        check("sr_chkcnt",   8'(chkcnt2), 8'h0);
        check("sr_synced",   8'(synced2), 8'h0);
        check("sr_expq",     8'(expq2),   8'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule : tb_counter_4b_checker
